// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csa_pkg
// Description : Shared types and parameter checks for the carry-save accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        HOLD    = 2'd2
    } csa_state_t;

    // Result must hold an operand and split evenly into resolve chunks.
    function automatic bit csa_params_ok(input int width, input int acc_width, input int chunk);
        return (acc_width >= width) && (chunk > 0) && ((acc_width % chunk) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : csa_accum_if
// Description : Operand-in / result-out valid-ready bundle for csa_accum.
// Revision    : 1.0 - initial release
// ============================================================================
interface csa_accum_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/csa_row.sv
`default_nettype none
// ============================================================================
// Module      : csa_row
// Description : N-bit 3:2 compressor row producing sum and majority vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_row #(
    parameter int N = 16
) (
    input  wire logic [N-1:0] i_a,
    input  wire logic [N-1:0] i_b,
    input  wire logic [N-1:0] i_c,
    output logic      [N-1:0] o_sum,
    output logic      [N-1:0] o_maj
);
    assign o_sum = i_a ^ i_b ^ i_c;
    assign o_maj = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule
`default_nettype wire

// File: rtl/csa_accum.sv
`default_nettype none
// ============================================================================
// Module      : csa_accum
// Description : Carry-save stream accumulator with chunked carry-propagate resolve.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_accum
    import csa_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CHUNK     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    csa_accum_if.slave bus
);
    localparam int c_nchunk = ACC_WIDTH / CHUNK;
    localparam int c_idx_w  = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nchunk - 1);

    generate
        if (!csa_params_ok(WIDTH, ACC_WIDTH, CHUNK)) begin : g_param_check
            $error("csa_accum: need ACC_WIDTH >= WIDTH and ACC_WIDTH divisible by CHUNK");
        end
    endgenerate

    csa_state_t           r_state;
    logic [ACC_WIDTH-1:0] r_sum;
    logic [ACC_WIDTH-1:0] r_carry;
    logic [CHUNK-1:0]     r_res [c_nchunk];
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_ovf;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_cin;

    logic [ACC_WIDTH-1:0] w_x;
    logic [ACC_WIDTH-1:0] w_row_sum;
    logic [ACC_WIDTH-1:0] w_row_maj;
    logic [ACC_WIDTH-1:0] w_result;
    logic [CHUNK-1:0]     w_s_chunk [c_nchunk];
    logic [CHUNK-1:0]     w_c_chunk [c_nchunk];
    logic [CHUNK:0]       w_chunk_add;

    assign w_x = ACC_WIDTH'(bus.in_data);

    csa_row #(.N(ACC_WIDTH)) u_row (
        .i_a   (r_sum),
        .i_b   (r_carry),
        .i_c   (w_x),
        .o_sum (w_row_sum),
        .o_maj (w_row_maj)
    );

    generate
        for (genvar k = 0; k < c_nchunk; k++) begin : g_chunk
            assign w_s_chunk[k]                 = r_sum[k*CHUNK +: CHUNK];
            assign w_c_chunk[k]                 = r_carry[k*CHUNK +: CHUNK];
            assign w_result[k*CHUNK +: CHUNK]   = r_res[k];
        end
    endgenerate

    assign w_chunk_add = {1'b0, w_s_chunk[r_idx]} + {1'b0, w_c_chunk[r_idx]}
                       + {{CHUNK{1'b0}}, r_cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_sum   <= '0;
            r_carry <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
            r_cin   <= 1'b0;
            for (int k = 0; k < c_nchunk; k++) r_res[k] <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (bus.in_valid) begin
                        r_sum   <= w_row_sum;
                        r_carry <= w_row_maj << 1;
                        // A majority bit leaving the MSB is 2^ACC_WIDTH dropped from the pair.
                        if (w_row_maj[ACC_WIDTH-1]) r_ovf <= 1'b1;
                        if (r_count != '1) r_count <= r_count + CNT_WIDTH'(1);
                        if (bus.in_last) begin
                            r_state <= RESOLVE;
                            r_idx   <= '0;
                            r_cin   <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    r_res[r_idx] <= w_chunk_add[CHUNK-1:0];
                    r_cin        <= w_chunk_add[CHUNK];
                    r_idx        <= r_idx + c_idx_w'(1);
                    if (r_idx == c_last_idx) begin
                        r_ovf   <= r_ovf | w_chunk_add[CHUNK];
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_sum   <= '0;
                        r_carry <= '0;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ACCUM);
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_sum   = w_result;
    assign bus.out_count = r_count;
    assign bus.out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_csa_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_csa_accum
// Description : Directed and randomized checks of csa_accum against an integer-sum model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_accum;
    localparam int WIDTH     = 8;
    localparam int ACC_WIDTH = 16;
    localparam int CHUNK     = 4;
    localparam int CNT_WIDTH = 8;
    localparam int NCHUNK    = ACC_WIDTH / CHUNK;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    csa_accum_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) ifc ();

    csa_accum #(
        .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .CHUNK(CHUNK), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    longint m_tot = 0;
    int     m_n   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: true integer sum of the batch, reduced by plain arithmetic.
    task automatic check_result(input string tag, input longint tot, input int n);
        check({tag, "_sum"},   32'(ifc.out_sum), 32'(tot % 65536));
        check({tag, "_count"}, 32'(ifc.out_count), 32'((n > 255) ? 255 : n));
        check({tag, "_ovf"},   32'(ifc.out_ovf), 32'(tot >= 65536));
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [7:0] d, input logic l);
        int waited = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        ifc.in_last  = l;
        while (!ifc.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!ifc.in_ready) check("push_timeout", 32'(ifc.in_ready), 32'd1);
        @(negedge clk);
        m_tot += longint'(d);
        m_n++;
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!ifc.out_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check("wait_valid", 32'(ifc.out_valid), 32'd1);
    endtask

    task automatic take();
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        m_tot = 0;
        m_n   = 0;
        check("ready_after_take", 32'(ifc.in_ready), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  32'(ifc.in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(ifc.out_valid), 32'd0);
        check({tag, "_sum"},       32'(ifc.out_sum), 32'h0000);
        check({tag, "_count"},     32'(ifc.out_count), 32'd0);
        check({tag, "_ovf"},       32'(ifc.out_ovf), 32'd0);
    endtask

    initial begin
        int cyc;
        int idx;
        int nres;
        int lat;
        logic prev_valid;
        logic accepting;
        logic [ACC_WIDTH-1:0] held_sum;
        logic [7:0] ops [200];

        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Three 0xFF operands, latency from last accept to out_valid.
        push(8'hFF, 1'b0);
        push(8'hFF, 1'b0);
        push(8'hFF, 1'b1);
        check("in_ready_drop", 32'(ifc.in_ready), 32'd0);
        wait_valid(lat);
        check("latency", 32'(lat), 32'(NCHUNK));
        check("three_ff_sum_const", 32'(ifc.out_sum), 32'h02FD);
        check_result("three_ff", m_tot, m_n);
        take();

        // Overflow: 258 x 0xFF, then the 257 x 0xFF boundary.
        for (int i = 0; i < 258; i++) push(8'hFF, i == 257);
        wait_valid(lat);
        check("ovf258_sum_const", 32'(ifc.out_sum), 32'h00FE);
        check_result("ovf258", m_tot, m_n);
        take();
        for (int i = 0; i < 257; i++) push(8'hFF, i == 256);
        wait_valid(lat);
        check("ovf257_sum_const", 32'(ifc.out_sum), 32'hFFFF);
        check_result("ovf257", m_tot, m_n);
        take();

        // Backpressure with a pending operand on the input.
        push(8'h11, 1'b0);
        push(8'h22, 1'b1);
        wait_valid(lat);
        held_sum     = ifc.out_sum;
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'h77;
        ifc.in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_sum_stable", 32'(ifc.out_sum), 32'(held_sum));
            check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
            check("bp_out_valid", 32'(ifc.out_valid), 32'd1);
        end
        check_result("bp", m_tot, m_n);
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        take();
        push(8'h05, 1'b1);
        wait_valid(lat);
        check_result("single", m_tot, m_n);
        take();

        // Reset after two resolve chunks aborts the batch.
        push(8'h40, 1'b0);
        push(8'h30, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        m_tot = 0;
        m_n   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("aborted_no_valid", 32'(ifc.out_valid), 32'd0);
        end
        push(8'h01, 1'b0);
        push(8'h02, 1'b1);
        wait_valid(lat);
        check("after_reset_sum_const", 32'(ifc.out_sum), 32'h0003);
        check_result("after_reset", m_tot, m_n);
        take();

        // Streaming: valid/ready held high, junk presented whenever the block is not ready.
        for (int i = 0; i < 200; i++) ops[i] = 8'($urandom_range(0, 255));
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        idx        = 0;
        nres       = 0;
        cyc        = 0;
        prev_valid = 1'b0;
        while (nres < 100 && cyc < 3000) begin
            if (ifc.out_valid) begin
                check("hold_one_cycle", 32'(prev_valid), 32'd0);
                check_result("stream", longint'(ops[2*nres]) + longint'(ops[2*nres+1]), 2);
                nres++;
            end
            prev_valid = ifc.out_valid;
            if (ifc.in_ready && idx < 200) begin
                ifc.in_data  = ops[idx];
                ifc.in_last  = (idx % 2) == 1;
                accepting    = 1'b1;
            end else begin
                ifc.in_data  = 8'($urandom);
                ifc.in_last  = 1'($urandom);
                ifc.in_valid = (idx < 200);
                accepting    = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (accepting) idx++;
        end
        check("stream_results", 32'(nres), 32'd100);
        check("stream_ops", 32'(idx), 32'd200);
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
